// File: rtl/bus_router.sv
// bus_router: memory-map router from the 8-bit core bus to N target regions with wait states, external ready and timeout
module bus_router #(
    parameter int N = 3,
    parameter int AW = 20,
    parameter int DW = 8,
    parameter logic [N*AW-1:0] REGION_BASE = {20'hF0000, 20'hB8000, 20'h00000},
    parameter logic [N*AW-1:0] REGION_MASK = {20'hFE000, 20'hFE000, 20'hC0000},
    parameter logic [N*4-1:0] REGION_WAIT = {4'd0, 4'd0, 4'd0},
    parameter logic [N-1:0] REGION_EXT = 3'b000,
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic [AW-1:0] address,
    input  logic [DW-1:0] data,
    input  logic req,
    input  logic wreq,
    output logic [DW-1:0] bus,
    output logic ready,
    output logic [N-1:0] region_sel,
    output logic [N-1:0] region_we,
    output logic [AW-1:0] region_addr,
    output logic [DW-1:0] region_data,
    input  logic [N*DW-1:0] region_q,
    input  logic [N-1:0] region_ready,
    output logic err,
    output logic [AW-1:0] err_addr
);
    localparam int IW = N > 1 ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;
    logic hit, hit_l, we_l, fin, tmo;
    logic [IW-1:0] hit_idx, idx;
    logic [3:0] wait_cnt;
    logic [7:0] to_cnt;
    // lowest matching region index wins, decoded from the live address
    always_comb begin
        hit = 1'b0;
        hit_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if ((address & REGION_MASK[i*AW +: AW]) == REGION_BASE[i*AW +: AW]) begin
                hit = 1'b1;
                hit_idx = IW'(i);
            end
    end
    // next state and state-derived strobes; completion beats timeout in the same cycle
    always_comb begin
        fin = wait_cnt == 4'd0 && (!REGION_EXT[idx] || region_ready[idx]);
        tmo = wait_cnt == 4'd0 && !fin && to_cnt == 8'(TIMEOUT);
        state_nx = state == IDLE ? (req ? (hit ? BUSY : DONE) : IDLE)
                 : state == BUSY ? (fin || tmo ? DONE : BUSY)
                 : IDLE;
        ready = state == DONE;
        region_sel = state != IDLE && hit_l ? N'(1) << idx : '0;
        region_we = state == BUSY && to_cnt == 8'd0 && we_l ? N'(1) << idx : '0;
    end
    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    // transaction latches, wait/timeout counters, read data and sticky error
    always_ff @(posedge clock) begin
        if (reset) begin
            bus <= '1;
            region_addr <= '0;
            region_data <= '0;
            err <= 1'b0;
            err_addr <= '0;
            hit_l <= 1'b0;
            we_l <= 1'b0;
            idx <= '0;
            wait_cnt <= '0;
            to_cnt <= '0;
        end else if (state == IDLE && req) begin
            region_addr <= address;
            region_data <= data;
            we_l <= wreq;
            idx <= hit_idx;
            hit_l <= hit;
            wait_cnt <= hit ? REGION_WAIT[int'(hit_idx)*4 +: 4] : 4'd0;
            to_cnt <= '0;
            if (!hit) bus <= '1;
        end else if (state == BUSY) begin
            to_cnt <= to_cnt + 8'd1;
            if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
            else if (fin) begin
                if (!we_l) bus <= region_q[int'(idx)*DW +: DW];
            end else if (tmo) begin
                bus <= '1;
                if (!err) begin
                    err <= 1'b1;
                    err_addr <= region_addr;
                end
            end
        end
    end
endmodule

// File: doc/bus_router.md
Name: bus_router

Overview:
- Parametrised memory-map router between the 8-bit core bus and N target regions.
- Successor to the fixed combinational casex decode in the board top.
- Adds per-region wait states, an external-ready handshake for slow devices (SDRAM, SD buffers) and timeout detection.
- Sits between core88 and the memory/peripheral blocks in every board top.

Parameters:
- N, 3, number of regions.
- AW, 20, address width.
- DW, 8, data width.
- REGION_BASE, {20'hF0000,20'hB8000,20'h00000}, packed N*AW bases; region i is bits [i*AW +: AW].
- REGION_MASK, {20'hFE000,20'hFE000,20'hC0000}, packed N*AW match masks.
- REGION_WAIT, {4'd0,4'd0,4'd0}, packed N*4 wait-state counts.
- REGION_EXT, 3'b000, bit i=1 means region i also waits for region_ready[i].
- TIMEOUT, 255, maximum BUSY cycles before forced completion (8-bit counter).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- address  in  AW  core address
- data  in  DW  core write data
- req  in  1  transaction request, sampled in IDLE only
- wreq  in  1  1=write, 0=read, sampled with req
- bus  out  DW  registered read data to core
- ready  out  1  one-cycle completion strobe
- region_sel  out  N  one-hot select, held for the whole transaction
- region_we  out  N  one-hot write pulse, first BUSY cycle only
- region_addr  out  AW  latched address
- region_data  out  DW  latched write data
- region_q  in  N*DW  packed read data from targets
- region_ready  in  N  external ready, used only where REGION_EXT[i]=1
- err  out  1  sticky timeout flag
- err_addr  out  AW  address of the first timed-out transaction

Behaviour:
- Reset values: state IDLE, ready=0, bus=FF, region_sel=0, region_we=0, region_addr=0, region_data=0, err=0, err_addr=0, counters 0.
- Decode: region i matches when (address & MASK_i) == BASE_i. The lowest matching index wins. Decode is evaluated on the unlatched address in IDLE.
- IDLE, req=1 at cycle T0:
  - Latch address, data, wreq and the decoded index.
  - No match: go to DONE with bus=FF; ready=1 at T1. Writes to unmapped space are discarded.
  - Match i: go to BUSY. region_sel[i]=1 from T1; region_we[i]=1 at T1 only, if wreq.
  - Wait counter loads REGION_WAIT[i]; timeout counter loads 0.
- BUSY, each cycle:
  - Timeout counter increments.
  - If wait counter>0, decrement it.
  - Else, if REGION_EXT[i]=0 or region_ready[i]=1: capture region_q[i] into bus (reads only; bus keeps its prior value on writes) and go to DONE.
  - Else, if timeout counter == TIMEOUT: bus=FF. If err=0, set err=1 and latch err_addr. Go to DONE.
  - Completion takes priority over timeout when both occur in the same cycle.
- DONE: ready=1 for exactly one cycle, region_sel stays asserted, then return to IDLE with region_sel=0. req is ignored in DONE.
- Latency:
  - Unmapped: ready at T1.
  - Internal region, WAIT=w: ready at T2+w.
  - External region: ready one cycle after the first cycle in which the wait counter is 0 and region_ready=1.
- Back-to-back: with req held high, a new transaction starts in the IDLE cycle after DONE. Minimum period is 3 cycles for WAIT=0.
- Changes to req, address or data outside IDLE have no effect.
- err clears only on reset. Later timeouts do not overwrite err_addr.
- Reset mid-transaction: next cycle returns to reset values. No ready is issued and no further we pulse occurs.
- Regions whose REGION_EXT bit is 0 ignore region_ready entirely.

Test Plan:
- Defaults, read 0x00123 with region_q[7:0]=5A → sel=001 at T1, ready at T2, bus=5A; region_sel=0 at T3.
- Write 0xB8010 data 3C → region_we=010 at T1 only, region_addr=B8010, region_data=3C, ready at T2; bus unchanged.
- Read 0x50000 (unmapped) → region_sel stays 0, ready at T1, bus=FF; write to 0x50000 produces no region_we.
- REGION_WAIT[2]=3, read 0xF0000 → ready at T5; REGION_EXT[0]=1 with region_ready held 0 and TIMEOUT=10 → bus=FF, err=1, err_addr latched. A second timeout leaves err_addr unchanged.
- REGION_BASE/MASK set so regions 0 and 1 overlap at 0x38000 → region_sel=001 (index 0 wins).
- req held high across 3 reads → ready pulses every 3 cycles. Reset asserted at T1 of a write → region_we=0 and ready=0 from T2, with all outputs at reset values.
